// File: rtl/ysyx_22040632_mul_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_pkg
// Shared definitions for the iterative multiplier:
//   - FSM state encoding
//   - mul_signed operand-signedness encodings (SS / SU / UU)
//   - iteration counts per operating mode and radix
// Build option: YSYX_22040632_MUL_RADIX4_EN selects the radix-4 datapath
// (two multiplier bits retired per BUSY cycle); undefined gives radix-2.
// ----------------------------------------------------------------------------
package ysyx_22040632_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    // mul_signed encodings; 2'b01 is not listed and behaves as UU.
    localparam logic [1:0] MUL_SS = 2'b11;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b00;

    localparam int CNT_W = 7;

`ifdef YSYX_22040632_MUL_RADIX4_EN
    localparam logic [CNT_W-1:0] ITER_DWORD = 7'd32;
    localparam logic [CNT_W-1:0] ITER_WORD  = 7'd16;
`else
    localparam logic [CNT_W-1:0] ITER_DWORD = 7'd64;
    localparam logic [CNT_W-1:0] ITER_WORD  = 7'd32;
`endif

endpackage

// File: rtl/ysyx_22040632_mul_opprep.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_opprep
// Combinational operand preparation: extends the operands (32-bit low halves
// when mulw=1), then produces their magnitudes and the product sign.
// Ports:
//   multiplicand, multiplier : raw 64-bit operands A and B
//   mulw                     : 32-bit operation, use bits [31:0] only
//   mul_signed               : SS / SU / UU signedness selector
//   abs_a, abs_b             : unsigned magnitudes (|-2^63| = 2^63 fits)
//   neg                      : final product must be negated
// ----------------------------------------------------------------------------
module ysyx_22040632_mul_opprep
    import ysyx_22040632_mul_pkg::*;
(
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    input  logic        mulw,
    input  logic [1:0]  mul_signed,
    output logic [63:0] abs_a,
    output logic [63:0] abs_b,
    output logic        neg
);

    logic        a_is_signed;
    logic        b_is_signed;
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic        sign_a;
    logic        sign_b;

    assign a_is_signed = (mul_signed == MUL_SS) || (mul_signed == MUL_SU);
    assign b_is_signed = (mul_signed == MUL_SS);

    always_comb begin
        if (mulw) begin
            ext_a = a_is_signed ? {{32{multiplicand[31]}}, multiplicand[31:0]}
                                : {32'd0, multiplicand[31:0]};
            ext_b = b_is_signed ? {{32{multiplier[31]}}, multiplier[31:0]}
                                : {32'd0, multiplier[31:0]};
        end else begin
            ext_a = multiplicand;
            ext_b = multiplier;
        end
    end

    assign sign_a = a_is_signed & ext_a[63];
    assign sign_b = b_is_signed & ext_b[63];

    // Two's-complement negation read back as unsigned covers -2^63 -> 2^63.
    assign abs_a = sign_a ? (~ext_a + 64'd1) : ext_a;
    assign abs_b = sign_b ? (~ext_b + 64'd1) : ext_b;
    assign neg   = sign_a ^ sign_b;

endmodule

// File: rtl/ysyx_22040632_mul_iter.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_iter
// Iterative shift-add multiplier, 64x64->128 or 32-bit MULW, signed/unsigned.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   mul_valid         : request valid, sampled while mul_ready=1
//   flush             : cancel in-flight op, blocks acceptance this cycle
//   mulw, mul_signed  : operation mode / operand signedness
//   multiplicand      : operand A,  multiplier : operand B
//   mul_ready         : idle, can accept
//   out_valid         : one-cycle result strobe
//   result_hi/lo      : product words, held until the next completion
// Build option: YSYX_22040632_MUL_RADIX4_EN retires two multiplier bits per
// BUSY cycle using a precomputed 3|A|; results are identical to radix-2.
// ----------------------------------------------------------------------------
module ysyx_22040632_mul_iter
    import ysyx_22040632_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic        mulw,
    input  logic [1:0]  mul_signed,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [127:0]     prod_q;
    logic [127:0]     prod_step;
    logic [63:0]      abs_a_q;
    logic             neg_q;
    logic             mulw_q;
    logic [63:0]      abs_a, abs_b;
    logic             neg;
    logic             accept;
    logic [127:0]     mag;
    logic [127:0]     signed_prod;

    ysyx_22040632_mul_opprep u_opprep (
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .abs_a        (abs_a),
        .abs_b        (abs_b),
        .neg          (neg)
    );

    assign mul_ready = (state_q == ST_IDLE);
    assign accept    = mul_valid & mul_ready & ~flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
                if (flush)               state_d = ST_IDLE;
                else if (cnt_q == 7'd1)  state_d = ST_SIGN;
            end
            ST_SIGN: state_d = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= mulw ? ITER_WORD : ITER_DWORD;
            else if (state_q == ST_BUSY)
                cnt_q <= cnt_q - 7'd1;
        end
    end

    // Iteration step: add the selected multiple of |A| into the upper half,
    // then shift right by the number of retired multiplier bits.
`ifdef YSYX_22040632_MUL_RADIX4_EN
    logic [65:0] a3_q;
    logic [65:0] addend;
    logic [65:0] sum;

    always_comb begin
        addend = 66'd0;
        case (prod_q[1:0])
            2'b00: addend = 66'd0;
            2'b01: addend = {2'b00, abs_a_q};
            2'b10: addend = {1'b0, abs_a_q, 1'b0};
            2'b11: addend = a3_q;
            default: addend = 66'd0;
        endcase
    end

    assign sum       = {2'b00, prod_q[127:64]} + addend;
    assign prod_step = {sum, prod_q[63:2]};

    always_ff @(posedge clk) begin
        if (accept)
            a3_q <= {2'b00, abs_a} + {1'b0, abs_a, 1'b0};
    end
`else
    logic [64:0] sum;

    assign sum       = {1'b0, prod_q[127:64]} + (prod_q[0] ? {1'b0, abs_a_q} : 65'd0);
    assign prod_step = {sum, prod_q[63:1]};
`endif

    // Operand/product registers carry no reset: they are always loaded on
    // accept before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            abs_a_q <= abs_a;
            neg_q   <= neg;
            mulw_q  <= mulw;
            prod_q  <= {64'd0, abs_b};
        end else if (state_q == ST_BUSY) begin
            prod_q  <= prod_step;
        end
    end

    // After 32 bits retired for MULW the magnitude sits at P[95:32]
    // (the unretired multiplier bits were all zero).
    assign mag         = mulw_q ? {64'd0, prod_q[95:32]} : prod_q;
    assign signed_prod = neg_q ? (~mag + 128'd1) : mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            out_valid <= (state_q == ST_SIGN) && !flush;
            if ((state_q == ST_SIGN) && !flush) begin
                if (mulw_q) begin
                    result_hi <= signed_prod[63:0];
                    result_lo <= {{32{signed_prod[31]}}, signed_prod[31:0]};
                end else begin
                    result_hi <= signed_prod[127:64];
                    result_lo <= signed_prod[63:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_mul_iter.sv
module tb_ysyx_22040632_mul_iter;

`ifdef YSYX_22040632_MUL_RADIX4_EN
    localparam int LAT_D = 34;
    localparam int LAT_W = 18;
`else
    localparam int LAT_D = 66;
    localparam int LAT_W = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mul_valid = 1'b0;
    logic        flush = 1'b0;
    logic        mulw = 1'b0;
    logic [1:0]  mul_signed = 2'b00;
    logic [63:0] multiplicand = '0;
    logic [63:0] multiplier = '0;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_hi = '0;
    logic [63:0] last_lo = '0;

    always #5 clk = ~clk;

    ysyx_22040632_mul_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        w;
        logic [1:0]  s;
        logic [63:0] hi;
        logic [63:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide multiplication of the sign/zero-extended operands.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic w, input logic [1:0] s);
        logic         as_, bs_;
        logic [127:0] ea, eb, p;
        logic [63:0]  q;
        as_ = s[1];
        bs_ = (s == 2'b11);
        if (w) begin
            ea = as_ ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
            eb = bs_ ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
            p  = ea * eb;
            q  = p[63:0];
            return {q, {32{q[31]}}, q[31:0]};
        end
        ea = as_ ? {{64{a[63]}}, a} : {64'd0, a};
        eb = bs_ ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                          input logic [1:0] s, input logic [63:0] eh, input logic [63:0] el,
                          input string tag);
        int  lat;
        bit  ready_ok;
        int  exp_lat;
        exp_lat = w ? LAT_W : LAT_D;
        @(negedge clk);
        chk({tag, ".ready_before"}, {63'd0, mul_ready}, 64'd1);
        multiplicand = a;
        multiplier   = b;
        mulw         = w;
        mul_signed   = s;
        mul_valid    = 1'b1;
        @(posedge clk);
        #1;
        mul_valid    = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        mulw         = 1'($urandom);
        mul_signed   = 2'($urandom);
        lat = 0;
        ready_ok = 1'b1;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c;
            if (mul_ready) ready_ok = 1'b0;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".hi"}, result_hi, eh);
        chk({tag, ".lo"}, result_lo, el);
        chk({tag, ".ready_low"}, {63'd0, ready_ok}, 64'd1);
        @(negedge clk);
        chk({tag, ".ready_after"}, {63'd0, mul_ready}, 64'd1);
        chk({tag, ".valid_once"}, {63'd0, out_valid}, 64'd0);
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        mulw         = 1'b0;
        mul_signed   = 2'b00;
        mul_valid    = 1'b1;
        @(posedge clk);
        #1;
        mul_valid    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'd3, 64'd5, 1'b0, 2'b00, 64'd0, 64'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b11, 64'd0, 64'd1};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2'b11,
                    64'h4000_0000_0000_0000, 64'd0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[4] = '{64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 2'b11,
                    64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b01,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
        vecs[6] = '{64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF, 1'b1, 2'b00,
                    64'hFFFF_FFFE_0000_0001, 64'd1};
        vecs[7] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'b10,
                    64'hFFFF_FFFF_0000_0001, 64'd1};
        vecs[8] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 2'b11,
                    64'h4000_0000_0000_0000, 64'd0};

        // reset state
        #1;
        chk("reset.ready", {63'd0, mul_ready}, 64'd1);
        chk("reset.valid", {63'd0, out_valid}, 64'd0);
        chk("reset.hi", result_hi, 64'd0);
        chk("reset.lo", result_lo, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].s, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));

        // random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [63:0]  ra, rb;
            logic         rw;
            logic [1:0]   rs;
            logic [127:0] m;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 0) ra = {32'hFFFF_FFFF, $urandom};
            rw = 1'($urandom);
            rs = 2'($urandom);
            m  = model(ra, rb, rw, rs);
            run_op(ra, rb, rw, rs, m[127:64], m[63:0], $sformatf("rnd%0d", i));
        end

        // flush while idle blocks acceptance
        @(negedge clk);
        mul_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk("flush_idle.ready", {63'd0, mul_ready}, 64'd1);

        // flush in BUSY at iteration 10
        start_op(64'd123, 64'd456);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy.ready", {63'd0, mul_ready}, 64'd1);
        begin
            bit seen = 1'b0;
            for (int c = 0; c < LAT_D + 10; c++) begin
                if (out_valid) seen = 1'b1;
                @(negedge clk);
            end
            chk("flush_busy.no_valid", {63'd0, seen}, 64'd0);
        end
        chk("flush_busy.hi_hold", result_hi, last_hi);
        chk("flush_busy.lo_hold", result_lo, last_lo);
        run_op(64'd7, 64'd6, 1'b0, 2'b00, 64'd0, 64'd42, "after_flush");

        // asynchronous reset pulse mid-BUSY
        start_op(64'hFFFF_0000_1234_5678, 64'h0F0F_F0F0_0F0F_F0F0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", {63'd0, mul_ready}, 64'd1);
        chk("midrst.valid", {63'd0, out_valid}, 64'd0);
        chk("midrst.hi", result_hi, 64'd0);
        chk("midrst.lo", result_lo, 64'd0);
        #2;
        rst_n = 1'b1;
        begin
            logic [127:0] m;
            m = model(64'hFFFF_FFFF_FFFF_FFF9, 64'd1000, 1'b0, 2'b11);
            run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd1000, 1'b0, 2'b11, m[127:64], m[63:0],
                   "after_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_mul_iter.md
# ysyx_22040632_mul_iter

Iterative 64-bit multiplier; the execution-unit end of the CPU↔multiplier interface. Accepts one operation per handshake from the EX stage and computes signed/unsigned 64×64→128 (or 32-bit MULW) products by shift-add over multiple cycles. Returns `result_hi`/`result_lo` with a one-cycle `out_valid` strobe. The CPU can cancel an operation at any time with `flush`.

## Interface
- No parameters; widths are fixed by the interface (64-bit operands).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mul_valid` in 1: request valid. Sampled only while `mul_ready`=1.
- `flush` in 1: cancel any in-flight operation; blocks acceptance in the same cycle.
- `mulw` in 1: 32-bit (RV64 MULW) operation.
- `mul_signed` in 2: 2'b11 signed×signed, 2'b10 signed multiplicand × unsigned multiplier, 2'b00 unsigned×unsigned. 2'b01 is treated as 2'b00.
- `multiplicand` in 64: operand A.
- `multiplier` in 64: operand B.
- `mul_ready` out 1: idle, can accept a request. Reset 1.
- `out_valid` out 1: results valid for exactly this cycle. Registered; reset 0.
- `result_hi` out 64: upper product word. Registered; reset 0.
- `result_lo` out 64: lower product word. Registered; reset 0.

## Operation
- FSM states and behaviour:
  - IDLE: `mul_ready`=1.
  - BUSY: iterates.
  - SIGN: applies the final sign.
  - DONE: `out_valid`=1.
- Accept: `mul_valid & mul_ready & ~flush` at a rising edge.
  - Latch the absolute values of both operands.
  - Latch `neg` = sign(A)^sign(B), using signedness from `mul_signed`.
  - Latch `mulw`.
  - Load the 128-bit product register P: upper half 0, lower half |B|.
  - Load the iteration counter with N. Go to BUSY.
- Operand prep when `mulw`=1: take bits [31:0] of each operand and sign- or zero-extend them per `mul_signed` before taking magnitudes.
- |−2^63| = 2^63 is represented as an unsigned 64-bit value. There is no overflow case.
- BUSY iteration (radix-2), one per cycle:
  - If P[0]=1, then P[127:63] = P[127:64] + |A| as a 65-bit add.
  - Otherwise P shifts right by 1.
  - Decrement the counter. After the last iteration, go to SIGN.
- N = 64, or 32 when `mulw`=1.
- SIGN: the full product is the 128-bit two's-complement negation of P when `neg`=1, otherwise P. Write it to the result registers and go to DONE.
- `mulw` results:
  - Q is the 64-bit product of the extended 32-bit operands.
  - `result_lo` = {32{Q[31]}, Q[31:0]}.
  - `result_hi` = Q.
  - Q's bit alignment inside P is an implementation choice.
- DONE: `out_valid`=1 for one cycle, then IDLE unconditionally. There is no backpressure; the consumer must capture the result.
- Results hold their last value until the next SIGN→DONE write. They are not cleared on flush.
- `flush`:
  - In BUSY or SIGN: go to IDLE at the next edge. No `out_valid`; results are not updated.
  - In DONE: `out_valid` is still 1 in that cycle (already registered). Next state is IDLE.
  - In IDLE: blocks acceptance.
- `rst_n` low at any time, including mid-operation: immediately IDLE. All outputs return to their reset values.

## Timing
- Accept edge ends cycle T.
- BUSY for cycles T+1..T+N; SIGN at T+N+1; DONE (`out_valid`=1) at T+N+2.
- Latency is 66 cycles (64-bit) or 34 cycles (`mulw`) from the accept cycle to `out_valid`.
- `mul_ready`=0 from T+1 through T+N+2. It returns to 1 at T+N+3.
- Back-to-back ops: the next accept is at the earliest in cycle T+N+3.
- `mul_valid` held high while `mul_ready`=0 is ignored.

## Configuration
- `YSYX_22040632_MUL_RADIX4_EN` defined: 2 multiplier bits retired per BUSY cycle.
  - Add 0, |A|, 2|A| or 3|A|. 3|A| is a 66-bit value precomputed at the accept edge.
  - Shift P by 2. N = 32 (16 for `mulw`).
  - Latency is 34 cycles (64-bit) or 18 cycles (`mulw`).
- Macro undefined: radix-2 as described above.
- Results are bit-identical in both builds.

## Structure
- Package `ysyx_22040632_mul_pkg`:
  - FSM state enum.
  - `mul_signed` encoding constants (SS, SU, UU).
  - Iteration counts per mode and radix, selected by the macro.
- Sub-module `ysyx_22040632_mul_opprep` (combinational):
  - Inputs: operands, `mulw`, `mul_signed`.
  - Outputs: |A|, |B|, `neg`.
- The FSM, P register and sign stage stay in the top module.

## Test plan
- UU, `mulw`=0, 3×5:
  - `out_valid` only in cycle T+66.
  - hi=0, lo=15.
  - `mul_ready` low T+1..T+66, high at T+67.
- SS, −1×−1: hi=0, lo=1.
- SS, 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000: hi=0x4000_0000_0000_0000, lo=0.
- SU, 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF: hi=0xFFFF_FFFF_FFFF_FFFF, lo=1.
- SS `mulw`, 0x7FFF_FFFF × 2:
  - `out_valid` at T+34.
  - lo=0xFFFF_FFFF_FFFF_FFFE, hi=0x0000_0000_FFFF_FFFE.
- Flush in BUSY at iteration 10:
  - No `out_valid`; `mul_ready`=1 next cycle; results unchanged.
  - An immediate new 7×6 yields lo=42.
- Reset pulse mid-BUSY: outputs return to their reset values; the next op is correct.
- Repeat the full suite with `YSYX_22040632_MUL_RADIX4_EN` defined; latencies 34/18.
